// File: rtl/led_blinker_pkg.sv
// Shared register map and delay-word types for the multi-channel LED blinker.
package led_blinker_pkg;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_STATUS   = 5'd1;
    localparam logic [4:0] REG_DLY_BASE = 5'd2;
    localparam logic [4:0] REG_POL      = 5'd31;

    localparam int DEF_DLY_W = 16;

    typedef logic [DEF_DLY_W-1:0] dly_word_t;

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: counts ms ticks and toggles its state after each half-period.
module led_blink_chan #(
    parameter int DLY_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic [DLY_W-1:0] dly,
    input  logic             dly_wr,
    output logic             led_state
);

    logic [DLY_W-1:0] r_cnt;

    // Channel counter and toggle; a zero delay stalls the channel with its state held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= {DLY_W{1'b0}};
            led_state <= 1'b0;
        end else if (!en) begin
            r_cnt     <= {DLY_W{1'b0}};
            led_state <= 1'b0;
        end else if (dly_wr) begin
            r_cnt     <= {DLY_W{1'b0}};
        end else if (dly == {DLY_W{1'b0}}) begin
            r_cnt     <= {DLY_W{1'b0}};
        end else if (tick) begin
            if (r_cnt == dly - DLY_W'(1)) begin
                r_cnt     <= {DLY_W{1'b0}};
                led_state <= ~led_state;
            end else begin
                r_cnt     <= r_cnt + DLY_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_blinker_array.sv
// MMIO multi-channel LED blinker with shared ms prescaler.
// Optional output polarity register enabled by LED_BLINKER_POLARITY_EN.
module led_blinker_array
    import led_blinker_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DLY_W       = DEF_DLY_W,
    parameter int TICK_DIV    = 100000,
    parameter int DEFAULT_DLY = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    input  logic [4:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic [NUM_CH-1:0] led
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     r_presc;
    logic [NUM_CH-1:0] r_ctrl;
    logic [DLY_W-1:0]  r_dly [NUM_CH];
    logic [NUM_CH-1:0] w_state;
    logic [NUM_CH-1:0] w_en;
    logic [NUM_CH-1:0] w_dly_wr;
    logic              w_tick;
    logic              w_wr;
    logic              w_ctrl_wr;
    logic              w_unused;

    assign w_unused  = read ^ (^wr_data);
    assign w_wr      = cs && write;
    assign w_ctrl_wr = w_wr && (addr == REG_CTRL);
    assign w_tick    = (r_presc == PW'(TICK_DIV - 1));

    // A CTRL write that clears a bit disables that channel at the same edge.
    assign w_en = r_ctrl & ~({NUM_CH{w_ctrl_wr}} & ~wr_data[NUM_CH-1:0]);

    // Free-running prescaler producing the shared ms tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= {PW{1'b0}};
        end else if (w_tick) begin
            r_presc <= {PW{1'b0}};
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Control and delay register writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                r_dly[i] <= DLY_W'(DEFAULT_DLY);
            end
        end else if (w_wr) begin
            if (addr == REG_CTRL) begin
                r_ctrl <= wr_data[NUM_CH-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_dly_wr[i]) begin
                    r_dly[i] <= wr_data[DLY_W-1:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_dly_wr[g] = w_wr && (addr == REG_DLY_BASE + 5'(g));

        led_blink_chan #(
            .DLY_W(DLY_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick     (w_tick),
            .en       (w_en[g]),
            .dly      (r_dly[g]),
            .dly_wr   (w_dly_wr[g]),
            .led_state(w_state[g])
        );
    end

`ifdef LED_BLINKER_POLARITY_EN
    logic [NUM_CH-1:0] r_pol;

    // Polarity register; a disabled channel therefore drives its inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pol <= {NUM_CH{1'b0}};
        end else if (w_wr && (addr == REG_POL)) begin
            r_pol <= wr_data[NUM_CH-1:0];
        end
    end

    assign led = w_state ^ r_pol;
`else
    assign led = w_state;
`endif

    // Side-effect-free read mux.
    always_comb begin
        rd_data = 32'd0;
        case (addr)
            REG_CTRL:   rd_data = 32'(r_ctrl);
            REG_STATUS: rd_data = 32'(led);
`ifdef LED_BLINKER_POLARITY_EN
            REG_POL:    rd_data = 32'(r_pol);
`endif
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    rd_data = rd_data |
                        ((addr == REG_DLY_BASE + 5'(i)) ? 32'(r_dly[i]) : 32'd0);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_led_blinker_array.sv
// Directed bench for led_blinker_array with TICK_DIV=4 (tick every 4 clk).
module tb_led_blinker_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  led;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    led_blinker_array #(
        .NUM_CH     (4),
        .DLY_W      (16),
        .TICK_DIV   (4),
        .DEFAULT_DLY(500)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .read   (read),
        .write  (write),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .led    (led)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        step();
        cs = 1'b0; write = 1'b0; wr_data = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        read = 1'b1; addr = a;
        #1;
        chk(tag, rd_data, exp);
        read = 1'b0;
    endtask

    task automatic led_chk(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, led}, {28'd0, exp});
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = 5'd0; wr_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Reset values
        rd_chk("rst_ctrl", 5'd0, 32'd0);
        rd_chk("rst_status", 5'd1, 32'd0);
        rd_chk("rst_dly0", 5'd2, 32'd500);
        rd_chk("rst_dly3", 5'd5, 32'd500);
        led_chk("rst_led", 4'b0000);

        // Basic blink: DLY0=3 -> toggles every 12 clk, first at 3rd tick (P12)
        bus_write(5'd2, 32'd3);
        bus_write(5'd0, 32'd1);
        led_chk("blink_en", 4'b0000);
        wait_until(11);
        led_chk("blink_pre", 4'b0000);
        step();
        led_chk("blink_first", 4'b0001);
        rd_chk("blink_status", 5'd1, 32'd1);
        wait_until(23);
        led_chk("blink_hold", 4'b0001);
        step();
        led_chk("blink_second", 4'b0000);

        // Independent rates: ch1 every 8 clk, ch2 every 20 clk
        bus_write(5'd3, 32'd2);
        bus_write(5'd4, 32'd5);
        bus_write(5'd0, 32'd6);
        wait_until(31);
        led_chk("rates_31", 4'b0000);
        step();
        led_chk("rates_32", 4'b0010);
        wait_until(40);
        led_chk("rates_40", 4'b0000);
        wait_until(43);
        led_chk("rates_43", 4'b0000);
        step();
        led_chk("rates_44", 4'b0100);
        wait_until(48);
        led_chk("rates_48", 4'b0110);
        rd_chk("rates_status", 5'd1, 32'd6);
        wait_until(64);
        led_chk("rates_64", 4'b0010);
        bus_write(5'd0, 32'd4);
        led_chk("disable_ch1", 4'b0000);
        rd_chk("ctrl_4", 5'd0, 32'd4);
        wait_until(83);
        led_chk("ch2_83", 4'b0000);
        step();
        led_chk("ch2_84", 4'b0100);

        // Freeze by zero delay
        bus_write(5'd0, 32'd5);
        wait_until(96);
        led_chk("ch0_on_96", 4'b0101);
        bus_write(5'd2, 32'd0);
        led_chk("freeze_97", 4'b0101);
        wait_until(104);
        led_chk("freeze_104", 4'b0001);
        wait_until(120);
        rd_chk("freeze_status", 5'd1, 32'd1);
        rd_chk("freeze_dly0", 5'd2, 32'd0);

        // DLY write coinciding with expiry: no toggle, count restarts
        wait_until(121);
        bus_write(5'd2, 32'd2);
        wait_until(127);
        bus_write(5'd2, 32'd2);
        led_chk("coinc_128", 4'b0101);
        wait_until(135);
        led_chk("coinc_135", 4'b0101);
        step();
        led_chk("coinc_136", 4'b0100);

        // Unmapped address and STATUS writes are ignored
        bus_write(5'd20, 32'hFFFF_FFFF);
        rd_chk("unmapped_rd", 5'd20, 32'd0);
        rd_chk("unmapped_ctrl", 5'd0, 32'd5);
        rd_chk("unmapped_dly0", 5'd2, 32'd2);
        rd_chk("unmapped_dly2", 5'd4, 32'd5);
        rd_chk("unmapped_dly3", 5'd5, 32'd500);
        bus_write(5'd1, 32'hF);
        led_chk("status_wr_ign", 4'b0100);

        // Reset mid-blink
        rst = 1'b1;
        step();
        led_chk("midrst_led", 4'b0000);
        rd_chk("midrst_ctrl", 5'd0, 32'd0);
        rd_chk("midrst_dly0", 5'd2, 32'd500);
        rst = 1'b0;
        cyc = 0;

        // Re-enable reproduces exact timing; upper bits read 0
        bus_write(5'd2, 32'hABCD_0003);
        bus_write(5'd0, 32'hFFFF_FFF1);
        rd_chk("upper_dly0", 5'd2, 32'd3);
        rd_chk("upper_ctrl", 5'd0, 32'd1);
        wait_until(11);
        led_chk("reen_11", 4'b0000);
        step();
        led_chk("reen_12", 4'b0001);

`ifdef LED_BLINKER_POLARITY_EN
        bus_write(5'd0, 32'd0);
        led_chk("pol_off", 4'b0000);
        bus_write(5'd31, 32'd1);
        led_chk("pol_inv_idle", 4'b0001);
        rd_chk("pol_reg", 5'd31, 32'd1);
        rd_chk("pol_status", 5'd1, 32'd1);
        bus_write(5'd2, 32'd2);
        bus_write(5'd0, 32'd1);
        wait_until(23);
        led_chk("pol_23", 4'b0001);
        step();
        led_chk("pol_24", 4'b0000);
        rd_chk("pol_status_24", 5'd1, 32'd0);
        wait_until(32);
        led_chk("pol_32", 4'b0001);
`else
        bus_write(5'd31, 32'hF);
        rd_chk("addr31_rd", 5'd31, 32'd0);
        led_chk("addr31_led", 4'b0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
